instruction_loader: RTL and testbench

Byte-serial writer that fills the byte-addressed, big-endian instruction memory from a stream of 32-bit instruction words. It accepts words over a valid/ready handshake and emits four byte writes per word, most significant byte at the lowest address. It sits between a host or testbench program source and the instruction memory's write port, and runs before the processor is released from reset.

---
 rtl/instruction_loader.sv | 155 +++++++++++++++
 tb/tb_instruction_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Byte-serial loader: turns accepted 32-bit words into four big-endian byte writes.
// Optional running sum of accepted words enabled by defining LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [31:0]           in_data_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [ADDR_WIDTH-2:0] word_count_o,
  output logic [31:0]           checksum_o
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  // IDLE wait start | ACCEPT take one word | WRITE four byte strobes | DONE hold result

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [1:0]            k_q;
  logic [31:0]           word_q;
  logic                  last_q;
  logic                  in_ready_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            mem_wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overflow_q;
  logic [ADDR_WIDTH-2:0] word_count_q;

  logic [1:0]            k_d;
  logic [7:0]            byte_d;
  logic [ADDR_WIDTH:0]   ptr_sum_d;
  logic                  full_d;
  logic                  session_start_d;

  always_comb begin
    k_d = k_q + 2'd1;
    byte_d = word_q[7:0];
    unique case (k_d)
      2'd1:    byte_d = word_q[23:16];
      2'd2:    byte_d = word_q[15:8];
      default: byte_d = word_q[7:0];
    endcase
    // Carry out of pointer+4 means the next word would not fit below the top of memory.
    ptr_sum_d = {1'b0, ptr_q} + (ADDR_WIDTH+1)'(4);
    full_d = ptr_sum_d[ADDR_WIDTH];
    session_start_d = start_i && ((state_q == IDLE) || (state_q == DONE));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      k_q          <= '0;
      word_q       <= '0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q      <= ACCEPT;
            ptr_q        <= BASE;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        ACCEPT: begin
          if (in_valid_i) begin
            state_q     <= WRITE;
            word_q      <= in_data_i;
            last_q      <= in_last_i;
            k_q         <= 2'd0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ptr_q;
            mem_wdata_q <= in_data_i[31:24];
          end
        end
        WRITE: begin
          if (k_q != 2'd3) begin
            k_q         <= k_d;
            mem_addr_q  <= ptr_q + ADDR_WIDTH'(k_d);
            mem_wdata_q <= byte_d;
          end else begin
            mem_we_q     <= 1'b0;
            word_count_q <= word_count_q + (ADDR_WIDTH-1)'(1);
            if (!full_d) ptr_q <= ptr_sum_d[ADDR_WIDTH-1:0];
            if (last_q || full_d) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              overflow_q <= !last_q;
            end else begin
              state_q    <= ACCEPT;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      checksum_q <= '0;
    end else if (session_start_d) begin
      checksum_q <= '0;
    end else if ((state_q == ACCEPT) && in_valid_i) begin
      checksum_q <= checksum_q + in_data_i;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

  assign in_ready_o   = in_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overflow_o   = overflow_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: one instance at base 0, one at base 1016.
module tb_instruction_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, valid0, last0;
  logic [31:0] data0;
  logic        ready0, we0, busy0, done0, ovf0;
  logic [9:0]  addr0;
  logic [7:0]  wdata0;
  logic [8:0]  wc0;
  logic [31:0] cs0;

  logic        start1, valid1, last1;
  logic [31:0] data1;
  logic        ready1, we1, busy1, done1, ovf1;
  logic [9:0]  addr1;
  logic [7:0]  wdata1;
  logic [8:0]  wc1;
  logic [31:0] cs1;

  instruction_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .in_valid_i(valid0),
    .in_data_i(data0), .in_last_i(last0), .in_ready_o(ready0), .mem_we_o(we0),
    .mem_addr_o(addr0), .mem_wdata_o(wdata0), .busy_o(busy0), .done_o(done0),
    .overflow_o(ovf0), .word_count_o(wc0), .checksum_o(cs0)
  );

  instruction_loader #(.ADDR_WIDTH(10), .BASE_ADDR(1016)) dut_hi (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .in_valid_i(valid1),
    .in_data_i(data1), .in_last_i(last1), .in_ready_o(ready1), .mem_we_o(we1),
    .mem_addr_o(addr1), .mem_wdata_o(wdata1), .busy_o(busy1), .done_o(done1),
    .overflow_o(ovf1), .word_count_o(wc1), .checksum_o(cs1)
  );

  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  int         wr1 = 0;
  logic [9:0] first_addr1 = '0;

  always @(posedge clk) begin
    if (we0) mem0[addr0] <= wdata0;
    if (we1) begin
      mem1[addr1] <= wdata1;
      if (wr1 == 0) first_addr1 <= addr1;
      wr1 <= wr1 + 1;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cs_exp(input logic [31:0] v);
`ifdef LOADER_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  // Handshake one word, then check the four byte strobes and the gap cycle.
  task automatic push0(input logic [31:0] w, input logic l, input logic [9:0] base, input int start_at);
    int t;
    t = 0;
    valid0 = 1'b1; data0 = w; last0 = l;
    while (!ready0 && t < 20) begin
      tick();
      t++;
    end
    if (!ready0) begin
      chk("handshake_timeout", 64'd0, 64'd1);
      valid0 = 1'b0;
      return;
    end
    tick();
    valid0 = 1'b0; data0 = $urandom; last0 = ~l;
    for (int k = 0; k < 4; k++) begin
      chk("we", 64'(we0), 64'd1);
      chk("rdy_low", 64'(ready0), 64'd0);
      chk("addr", 64'(addr0), 64'(base) + 64'(k));
      chk("byte", 64'(wdata0), 64'(w[31-8*k -: 8]));
      if (k == start_at) start0 = 1'b1;
      tick();
      start0 = 1'b0;
    end
    chk("we_gap", 64'(we0), 64'd0);
  endtask

  logic [31:0] w3 [3];
  logic [31:0] w1 [3];
  int          xfer_c [3];
  int          idx, ncap, bad, n;
  logic        prev_rdy;
  logic [13:0] pat;

  initial begin
    rst = 1'b1;
    start0 = 0; valid0 = 0; last0 = 0; data0 = 0;
    start1 = 0; valid1 = 0; last1 = 0; data1 = 0;
    w3[0] = 32'h01020304; w3[1] = 32'h05060708; w3[2] = 32'h090A0B0C;
    w1[0] = 32'hAABBCCDD; w1[1] = 32'h11111111; w1[2] = 32'h22222222;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 64'(ready0), 64'd0);
    chk("rst_we", 64'(we0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    chk("rst_addr", 64'(addr0), 64'd0);
    chk("rst_wdata", 64'(wdata0), 64'd0);
    chk("rst_wc", 64'(wc0), 64'd0);
    chk("rst_cs", 64'(cs0), 64'd0);
    chk("rst_hi_addr", 64'(addr1), 64'd0);

    // Two-word session
    pulse_start0();
    chk("acc_ready", 64'(ready0), 64'd1);
    chk("acc_busy", 64'(busy0), 64'd1);
    push0(32'h8C220000, 1'b0, 10'd0, -1);
    chk("ready_back", 64'(ready0), 64'd1);
    push0(32'h00433820, 1'b1, 10'd4, -1);
    chk("t1_done", 64'(done0), 64'd1);
    chk("t1_busy", 64'(busy0), 64'd0);
    chk("t1_ready", 64'(ready0), 64'd0);
    chk("t1_wc", 64'(wc0), 64'd2);
    chk("t1_ovf", 64'(ovf0), 64'd0);
    chk("t1_cs", 64'(cs0), 64'(cs_exp(32'h8C653820)));
    chk("t1_mem", {mem0[0], mem0[1], mem0[2], mem0[3], mem0[4], mem0[5], mem0[6], mem0[7]},
        64'h8C22000000433820);

    // Idle in ACCEPT, then a zero word
    pulse_start0();
    chk("t2_wc_clr", 64'(wc0), 64'd0);
    chk("t2_done_clr", 64'(done0), 64'd0);
    chk("t2_cs_clr", 64'(cs0), 64'd0);
    bad = 0;
    repeat (10) begin
      tick();
      if (we0 || !ready0) bad++;
    end
    chk("t2_hold", 64'(bad), 64'd0);
    push0(32'h00000000, 1'b1, 10'd0, -1);
    chk("t2_mem", 64'({mem0[0], mem0[1], mem0[2], mem0[3]}), 64'd0);
    chk("t2_wc", 64'(wc0), 64'd1);
    chk("t2_done", 64'(done0), 64'd1);

    // start pulsed during WRITE is ignored
    pulse_start0();
    push0(32'h11223344, 1'b1, 10'd0, 1);
    chk("t4_done", 64'(done0), 64'd1);
    chk("t4_wc", 64'(wc0), 64'd1);
    chk("t4_cs", 64'(cs0), 64'(cs_exp(32'h11223344)));

    // Reset between the k=1 and k=2 writes
    pulse_start0();
    valid0 = 1'b1; data0 = 32'hA1B2C3D4; last0 = 1'b0;
    tick();
    valid0 = 1'b0;
    chk("t5_k0", 64'(wdata0), 64'hA1);
    tick();
    tick();
    chk("t5_k2", 64'(wdata0), 64'hC3);
    rst = 1'b1;
    #1;
    chk("t5_we", 64'(we0), 64'd0);
    chk("t5_ready", 64'(ready0), 64'd0);
    chk("t5_busy", 64'(busy0), 64'd0);
    chk("t5_done", 64'(done0), 64'd0);
    chk("t5_addr", 64'(addr0), 64'd0);
    chk("t5_wdata", 64'(wdata0), 64'd0);
    chk("t5_wc", 64'(wc0), 64'd0);
    chk("t5_cs", 64'(cs0), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_mem", 64'({mem0[0], mem0[1], mem0[2]}), 64'hA1B233);
    pulse_start0();
    push0(32'hDEADBEEF, 1'b1, 10'd0, -1);
    chk("t5_restart_wc", 64'(wc0), 64'd1);
    chk("t5_restart_cs", 64'(cs0), 64'(cs_exp(32'hDEADBEEF)));

    // Back-to-back words with in_valid held high
    pulse_start0();
    valid0 = 1'b1; data0 = w3[0]; last0 = 1'b0;
    idx = 0; ncap = 0; pat = '0;
    prev_rdy = ready0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (prev_rdy && idx < 3) begin
        xfer_c[idx] = c;
        idx++;
        if (idx < 3) begin
          data0 = w3[idx];
          last0 = (idx == 2);
        end else begin
          valid0 = 1'b0;
        end
      end
      if (idx > 0 && ncap < 14) begin
        pat = {pat[12:0], we0};
        ncap++;
      end
      prev_rdy = ready0;
    end
    chk("t6_xfers", 64'(idx), 64'd3);
    chk("t6_gap1", 64'(xfer_c[1] - xfer_c[0]), 64'd5);
    chk("t6_gap2", 64'(xfer_c[2] - xfer_c[1]), 64'd5);
    chk("t6_we_pat", 64'(pat), 64'(14'b11110111101111));
    chk("t6_done", 64'(done0), 64'd1);
    chk("t6_wc", 64'(wc0), 64'd3);
    chk("t6_cs", 64'(cs0), 64'(cs_exp(32'h0F121518)));

    // Memory fills at base 1016 before any in_last
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    valid1 = 1'b1; data1 = w1[0]; last1 = 1'b0;
    n = 0;
    prev_rdy = ready1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (prev_rdy) begin
        n++;
        if (n < 3) data1 = w1[n];
      end
      prev_rdy = ready1;
    end
    valid1 = 1'b0;
    chk("t7_xfers", 64'(n), 64'd2);
    chk("t7_done", 64'(done1), 64'd1);
    chk("t7_ovf", 64'(ovf1), 64'd1);
    chk("t7_wc", 64'(wc1), 64'd2);
    chk("t7_busy", 64'(busy1), 64'd0);
    chk("t7_writes", 64'(wr1), 64'd8);
    chk("t7_first_addr", 64'(first_addr1), 64'd1016);
    chk("t7_mem", {mem1[1016], mem1[1017], mem1[1018], mem1[1019],
                   mem1[1020], mem1[1021], mem1[1022], mem1[1023]}, 64'hAABBCCDD11111111);
    chk("t7_cs", 64'(cs1), 64'(cs_exp(32'hBBCCDDEE)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
